dual_rail_lut_eval: RTL and testbench
=====================================

Name: dual_rail_lut_eval

Overview:
Registered, parametrised N-input boolean function evaluator driven by dual-rail inputs: each variable arrives as a true rail and a complement rail.
- The function is held as a 2^N-entry truth table, loaded serially at run time or preset at reset.
- Each accepted input vector is rail-checked; consistent vectors are evaluated with 1-cycle latency, inconsistent ones are flagged and counted.
- Sits between dual-rail operand sources and downstream logic as the programmable successor to fixed 4-input transistor-level function cells.

Parameters:
N_IN, 4, number of logic inputs (1..6); table depth TT = 2^N_IN (derived, not overridable)
INIT_TT, 0, truth table value loaded on reset (TT bits, bit i = f(i))
INIT_READY, 0, 1 = table valid after reset (enter RUN); 0 = enter IDLE
ERR_W, 8, width of rail-error counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
cfg_start  input  1  pulse: begin (re)loading truth table
cfg_valid  input  1  cfg_bit qualifier
cfg_bit  input  1  serial truth-table bit
in_valid  input  1  input vector qualifier
in_true  input  N_IN  true rails
in_comp  input  N_IN  complement rails
tt_ready  output  1  truth table valid, evaluation enabled
out_valid  output  1  out is valid this cycle
out  output  1  function value
rail_err  output  1  1-cycle pulse: last accepted vector rail-inconsistent
err_count  output  ERR_W  saturating count of rail errors

Behaviour:
- Reset (rst=1 at edge):
  - tt <= INIT_TT; bit counter <= 0; out/out_valid/rail_err <= 0; err_count <= 0.
  - State <= RUN if INIT_READY else IDLE; tt_ready <= INIT_READY.
- States: IDLE, LOAD, RUN.
  - IDLE: inputs ignored, out_valid=0; cfg_start -> LOAD.
  - LOAD:
    - tt_ready=0; each cycle with cfg_valid=1: tt <= {cfg_bit, tt[TT-1:1]}, counter++.
    - First bit received ends in tt[0].
    - On the TT-th accepted bit: counter <= 0, state <= RUN, tt_ready=1 from the next cycle.
    - cfg_valid=0 cycles stall, with no timeout.
  - RUN: on in_valid=1, evaluate (below). cfg_start -> LOAD; tt_ready drops the next cycle, and an in_valid in that same cycle is ignored.
- cfg_start in LOAD: counter <= 0 (restart), and any cfg_bit that cycle is ignored; partially shifted bits are overwritten by the new load.
- cfg_start has priority over cfg_valid and in_valid in all states.
- Evaluation (RUN, in_valid=1), result registered, latency 1 cycle:
  - If in_true == ~in_comp: out <= tt[in_true], out_valid <= 1, rail_err <= 0.
  - Otherwise: out_valid <= 0, out holds its previous value, rail_err <= 1, err_count <= err_count+1, saturating at 2^ERR_W-1 (no wrap).
  - Rail-check covers both conflict cases: a rail pair of 11 or 00 on any variable is an error.
- in_valid=0 or not RUN: out_valid <= 0, rail_err <= 0, out holds.
- Back-to-back in_valid accepted every cycle; no backpressure.
- err_count is cleared only by rst; reloading the table does not clear it.
- rst mid-LOAD: partial table discarded, tt <= INIT_TT.

Test Plan:
1. Reset with INIT_READY=0 -> tt_ready=0, out_valid=0, err_count=0. Load 16 bits of 16'h8001 LSB-first -> tt_ready=1 on the cycle after the 16th bit. Drive in_true=4'hF/in_comp=4'h0 -> out=1, out_valid=1 one cycle later. Drive 4'h5/4'hA -> out=0.
2. Rail conflict in RUN: in_true=4'h3, in_comp=4'h3 -> rail_err pulse 1 cycle, out_valid=0, err_count=1. All-zero rails 4'h0/4'h0 -> err_count=2.
3. Saturation with ERR_W=2: 5 consecutive conflicting vectors -> err_count sequence 1,2,3,3,3.
4. Load interruption:
   - cfg_start after 7 bits, then a full 16-bit load of 16'h6996 -> table equals 16'h6996, and in_true=4'h7/4'h8 -> out=1.
   - Stall cfg_valid low for 5 cycles mid-load -> tt_ready stays 0 until the 16th bit.
5. cfg_start in RUN with in_valid=1 in the same cycle -> no out_valid, tt_ready=0 the next cycle. rst asserted mid-LOAD with INIT_READY=1, INIT_TT=16'hFFFF -> RUN, and any valid vector gives out=1.
6. Streaming: 16 consecutive in_valid cycles sweeping 0..15 with the 16'h6996 table -> out_valid high 16 cycles starting 1 cycle later, out = parity of each input.

Source files
------------

// File: rtl/dual_rail_lut_eval_if.sv
`default_nettype none
// ============================================================================
// Module   : dual_rail_lut_eval_if
// Brief    : Configuration, dual-rail operand and result bundle for the
//            programmable LUT evaluator.
// Revision : 1.0 - initial release
// ============================================================================
interface dual_rail_lut_eval_if #(
    parameter int N_IN  = 4,
    parameter int ERR_W = 8
);
    logic              cfg_start;
    logic              cfg_valid;
    logic              cfg_bit;
    logic              in_valid;
    logic [N_IN-1:0]   in_true;
    logic [N_IN-1:0]   in_comp;
    logic              tt_ready;
    logic              out_valid;
    logic              out;
    logic              rail_err;
    logic [ERR_W-1:0]  err_count;

    // Source side: drives configuration and operands, observes results
    modport master (
        output cfg_start, cfg_valid, cfg_bit, in_valid, in_true, in_comp,
        input  tt_ready, out_valid, out, rail_err, err_count
    );

    // Evaluator side
    modport slave (
        input  cfg_start, cfg_valid, cfg_bit, in_valid, in_true, in_comp,
        output tt_ready, out_valid, out, rail_err, err_count
    );
endinterface
`default_nettype wire

// File: rtl/dual_rail_lut_eval.sv
`default_nettype none
// ============================================================================
// Module   : dual_rail_lut_eval
// Brief    : Registered N-input boolean function evaluator with dual-rail
//            operands, serially loadable truth table and saturating
//            rail-error counter.
// Revision : 1.0 - initial release
// ============================================================================
module dual_rail_lut_eval #(
    parameter int                   N_IN       = 4,
    parameter logic [(2**N_IN)-1:0] INIT_TT    = '0,
    parameter bit                   INIT_READY = 1'b0,
    parameter int                   ERR_W      = 8
) (
    input wire                  clk,
    input wire                  rst,
    dual_rail_lut_eval_if.slave bus
);
    localparam int         c_tt = 2**N_IN;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_load = 2'd1;
    localparam logic [1:0] c_run  = 2'd2;
    localparam logic [1:0] c_reset_state = INIT_READY ? c_run : c_idle;

    logic [1:0]       r_state;
    logic [N_IN-1:0]  r_cnt;
    logic [c_tt-1:0]  r_tt;
    logic             r_out;
    logic             r_out_valid;
    logic             r_rail_err;
    logic [ERR_W-1:0] r_err_count;

    logic             w_rail_ok;
    logic             w_cnt_last;
    logic             w_err_sat;

    // A vector is consistent only when every rail pair is 10 or 01
    assign w_rail_ok  = &(bus.in_true ^ bus.in_comp);
    // Counter is N_IN wide, so all-ones marks the TT-th accepted bit
    assign w_cnt_last = (r_cnt == {N_IN{1'b1}});
    assign w_err_sat  = (r_err_count == {ERR_W{1'b1}});

    // Control, table shift register and registered evaluation result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_reset_state;
            r_cnt       <= '0;
            r_tt        <= INIT_TT;
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
            r_rail_err  <= 1'b0;
            r_err_count <= '0;
        end else begin
            // Result strobes are single-cycle unless an evaluation re-arms them
            r_out_valid <= 1'b0;
            r_rail_err  <= 1'b0;

            case (r_state)
                c_idle: begin
                    if (bus.cfg_start) begin
                        r_state <= c_load;
                        r_cnt   <= '0;
                    end
                end

                c_load: begin
                    if (bus.cfg_start) begin
                        // Restart: remaining stale bits get shifted out by the new load
                        r_cnt <= '0;
                    end else if (bus.cfg_valid) begin
                        r_tt <= {bus.cfg_bit, r_tt[c_tt-1:1]};
                        if (w_cnt_last) begin
                            r_cnt   <= '0;
                            r_state <= c_run;
                        end else begin
                            r_cnt <= r_cnt + N_IN'(1);
                        end
                    end
                end

                c_run: begin
                    if (bus.cfg_start) begin
                        // Reload wins over a vector presented in the same cycle
                        r_state <= c_load;
                        r_cnt   <= '0;
                    end else if (bus.in_valid) begin
                        if (w_rail_ok) begin
                            r_out       <= r_tt[bus.in_true];
                            r_out_valid <= 1'b1;
                        end else begin
                            r_rail_err <= 1'b1;
                            if (!w_err_sat) begin
                                r_err_count <= r_err_count + ERR_W'(1);
                            end
                        end
                    end
                end

                default: begin
                    r_state <= c_idle;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.tt_ready  = (r_state == c_run);
    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.rail_err  = r_rail_err;
    assign bus.err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_dual_rail_lut_eval.sv
`default_nettype none
// ============================================================================
// Module   : tb_dual_rail_lut_eval
// Brief    : Self-checking bench for dual_rail_lut_eval: directed load,
//            evaluation, conflict, saturation, reload and reset scenarios
//            plus randomized vectors against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dual_rail_lut_eval;
    logic clk;
    logic rst;
    logic rst_r;

    int n_vec  = 0;
    int n_fail = 0;

    // A: defaults; S: 2-bit error counter, preloaded parity table;
    // R: preloaded all-ones table for the mid-load reset scenario
    dual_rail_lut_eval_if #(.N_IN(4), .ERR_W(8)) ifa ();
    dual_rail_lut_eval_if #(.N_IN(4), .ERR_W(2)) ifs ();
    dual_rail_lut_eval_if #(.N_IN(4), .ERR_W(8)) ifr ();

    dual_rail_lut_eval #(.N_IN(4), .INIT_TT(16'h0000), .INIT_READY(1'b0), .ERR_W(8))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    dual_rail_lut_eval #(.N_IN(4), .INIT_TT(16'h6996), .INIT_READY(1'b1), .ERR_W(2))
        dut_s (.clk(clk), .rst(rst), .bus(ifs));
    dual_rail_lut_eval #(.N_IN(4), .INIT_TT(16'hFFFF), .INIT_READY(1'b1), .ERR_W(8))
        dut_r (.clk(clk), .rst(rst_r), .bus(ifr));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of DUT A: function table, readiness, held output, error tally
    logic [15:0] m_tt;
    bit          m_ready;
    logic        m_out;
    int          m_err;

    logic [3:0]  t;
    logic [3:0]  c;
    logic [15:0] rnd_tt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Serial LSB-first load of DUT A; optional 5-cycle cfg_valid stall before bit stall_at
    task automatic load_a(input logic [15:0] val, input int stall_at);
        ifa.in_valid  = 1'b0;
        ifa.cfg_start = 1'b1;
        ifa.cfg_valid = 1'b1;
        ifa.cfg_bit   = 1'b1;
        tick();
        ifa.cfg_start = 1'b0;
        m_ready = 1'b0;
        check("load_start_ready", ifa.tt_ready, 1'b0);
        for (int i = 0; i < 16; i++) begin
            if (i == stall_at) begin
                for (int k = 0; k < 5; k++) begin
                    ifa.cfg_valid = 1'b0;
                    tick();
                    check("load_stall_ready", ifa.tt_ready, 1'b0);
                end
            end
            ifa.cfg_valid = 1'b1;
            ifa.cfg_bit   = val[i];
            tick();
            check("load_bit_ready", ifa.tt_ready, (i == 15));
        end
        ifa.cfg_valid = 1'b0;
        m_tt    = val;
        m_ready = 1'b1;
    endtask

    // Present one vector to DUT A (in_valid left high for streaming) and check result
    task automatic apply_a(input logic [3:0] vt, input logic [3:0] vc);
        logic ev;
        logic ee;
        ifa.in_valid = 1'b1;
        ifa.in_true  = vt;
        ifa.in_comp  = vc;
        tick();
        ev = 1'b0;
        ee = 1'b0;
        if (m_ready) begin
            if ((vt ^ vc) == 4'hF) begin
                ev    = 1'b1;
                m_out = m_tt[vt];
            end else begin
                ee    = 1'b1;
                m_err = (m_err < 255) ? m_err + 1 : 255;
            end
        end
        check("a_out_valid", ifa.out_valid, ev);
        check("a_rail_err", ifa.rail_err, ee);
        check("a_out", ifa.out, m_out);
        check("a_err_count", ifa.err_count, m_err);
    endtask

    initial begin
        {ifa.cfg_start, ifa.cfg_valid, ifa.cfg_bit, ifa.in_valid} = '0;
        {ifs.cfg_start, ifs.cfg_valid, ifs.cfg_bit, ifs.in_valid} = '0;
        {ifr.cfg_start, ifr.cfg_valid, ifr.cfg_bit, ifr.in_valid} = '0;
        ifa.in_true = '0; ifa.in_comp = '0;
        ifs.in_true = '0; ifs.in_comp = '0;
        ifr.in_true = '0; ifr.in_comp = '0;
        m_tt = 16'h0000; m_ready = 1'b0; m_out = 1'b0; m_err = 0;

        rst   = 1'b1;
        rst_r = 1'b1;
        tick();
        tick();
        rst   = 1'b0;
        rst_r = 1'b0;

        // Reset state
        check("rst_a_tt_ready", ifa.tt_ready, 1'b0);
        check("rst_a_out_valid", ifa.out_valid, 1'b0);
        check("rst_a_err_count", ifa.err_count, 0);
        check("rst_s_tt_ready", ifs.tt_ready, 1'b1);
        check("rst_r_tt_ready", ifr.tt_ready, 1'b1);

        // IDLE ignores vectors
        apply_a(4'hF, 4'h0);
        ifa.in_valid = 1'b0;

        // Load 8001 and evaluate
        load_a(16'h8001, -1);
        apply_a(4'hF, 4'h0);
        check("tt8001_f", ifa.out, 1'b1);
        apply_a(4'h5, 4'hA);
        check("tt8001_5", ifa.out, 1'b0);

        // Rail conflicts: 11 pairs, then 00 pairs
        apply_a(4'h3, 4'h3);
        check("conflict11_count", ifa.err_count, 1);
        apply_a(4'h0, 4'h0);
        check("conflict00_count", ifa.err_count, 2);
        ifa.in_valid = 1'b0;
        tick();
        check("rail_err_pulse_end", ifa.rail_err, 1'b0);

        // Interrupted load after 7 bits, then full 6996 load with a stall
        ifa.cfg_start = 1'b1;
        tick();
        ifa.cfg_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            ifa.cfg_valid = 1'b1;
            ifa.cfg_bit   = 1'($urandom);
            tick();
        end
        m_ready = 1'b0;
        load_a(16'h6996, 9);
        apply_a(4'h7, 4'h8);
        check("tt6996_7", ifa.out, 1'b1);

        // cfg_start and in_valid together in RUN
        ifa.cfg_start = 1'b1;
        ifa.in_valid  = 1'b1;
        ifa.in_true   = 4'hE;
        ifa.in_comp   = 4'h1;
        tick();
        ifa.cfg_start = 1'b0;
        ifa.in_valid  = 1'b0;
        m_ready = 1'b0;
        check("cfgstart_run_out_valid", ifa.out_valid, 1'b0);
        check("cfgstart_run_tt_ready", ifa.tt_ready, 1'b0);
        check("cfgstart_run_out_hold", ifa.out, m_out);
        load_a(16'h6996, -1);

        // Streaming sweep: parity of each index
        for (int i = 0; i < 16; i++) begin
            t = 4'(i);
            apply_a(t, ~t);
            check("stream_parity", ifa.out, ^t);
        end
        ifa.in_valid = 1'b0;
        tick();
        check("stream_end_valid", ifa.out_valid, 1'b0);

        // Random table and randomized vectors with occasional rail corruption
        rnd_tt = 16'($urandom);
        load_a(rnd_tt, int'($urandom_range(1, 14)));
        for (int i = 0; i < 40; i++) begin
            t = 4'($urandom);
            c = ~t;
            if ($urandom_range(0, 3) == 0) c = c ^ 4'($urandom_range(1, 15));
            apply_a(t, c);
            if ($urandom_range(0, 4) == 0) begin
                ifa.in_valid = 1'b0;
                tick();
                check("rnd_idle_valid", ifa.out_valid, 1'b0);
            end
        end
        ifa.in_valid = 1'b0;
        check("err_not_cleared_by_reload", (ifa.err_count >= 8'd2), 1'b1);

        // Saturation on a 2-bit counter
        ifs.in_valid = 1'b1;
        ifs.in_true  = 4'h7;
        ifs.in_comp  = 4'h8;
        tick();
        check("s_valid_out", ifs.out, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            t = 4'($urandom);
            ifs.in_true = t;
            ifs.in_comp = t;
            tick();
            check("s_err_count", ifs.err_count, (k < 3) ? k : 3);
            check("s_rail_err", ifs.rail_err, 1'b1);
            check("s_out_valid", ifs.out_valid, 1'b0);
        end
        ifs.in_valid = 1'b0;

        // Reset in the middle of a load restores the preset table
        ifr.cfg_start = 1'b1;
        tick();
        ifr.cfg_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ifr.cfg_valid = 1'b1;
            ifr.cfg_bit   = 1'b0;
            tick();
        end
        check("r_midload_ready", ifr.tt_ready, 1'b0);
        ifr.cfg_valid = 1'b0;
        rst_r = 1'b1;
        tick();
        rst_r = 1'b0;
        check("r_after_rst_ready", ifr.tt_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            t = 4'($urandom);
            ifr.in_valid = 1'b1;
            ifr.in_true  = t;
            ifr.in_comp  = ~t;
            tick();
            check("r_out_valid", ifr.out_valid, 1'b1);
            check("r_out", ifr.out, 1'b1);
        end
        ifr.in_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
